// File: rtl/starfield_sequencer.sv
// rtl/starfield_sequencer.sv - frame-synchronous enable/gain/scroll controller for starfield layers
// Optional STARFIELD_SEQ_FRAME_COUNT_EN adds frame_count and vsync_overrun outputs.
module starfield_sequencer #(
    parameter int         NUM_LAYERS    = 3,
    parameter int         FADE_STEP     = 8,
    parameter logic [7:0] DEFAULT_GAIN  = 8'hFF,
    parameter logic [7:0] DEFAULT_SPEED = 8'd1
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic                    vsync_pulse,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_layer,
    input  logic [1:0]              cmd_op,
    input  logic [7:0]              cmd_data,
    output logic                    cmd_err,
    output logic [NUM_LAYERS-1:0]   layer_en,
    output logic [8*NUM_LAYERS-1:0] layer_gain,
    output logic [NUM_LAYERS-1:0]   layer_step,
    output logic                    fade_busy
`ifdef STARFIELD_SEQ_FRAME_COUNT_EN
    ,
    output logic [15:0]             frame_count,
    output logic                    vsync_overrun
`endif
);
    localparam logic [7:0] STEP8 = 8'(FADE_STEP);

    typedef enum logic [1:0] {IDLE, HOLD, UPDATE} state_t;
    state_t state, state_next;

    logic [7:0]            gain_q   [NUM_LAYERS];
    logic [7:0]            target_q [NUM_LAYERS];
    logic [7:0]            speed_q  [NUM_LAYERS];
    logic [7:0]            cnt_q    [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] en_q;

    logic       pending;
    logic [1:0] sh_layer;
    logic [1:0] sh_op;
    logic [7:0] sh_data;

    logic [7:0]            n_gain   [NUM_LAYERS];
    logic [7:0]            n_target [NUM_LAYERS];
    logic [7:0]            n_speed  [NUM_LAYERS];
    logic [7:0]            n_cnt    [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] n_en;
    logic [NUM_LAYERS-1:0] n_step;
    logic                  n_busy;

    logic accept;
    logic layer_ok;

    assign accept   = cmd_valid && cmd_ready;
    assign layer_ok = ({1'b0, cmd_layer} < 3'(NUM_LAYERS));

    always_comb begin
        state_next = state;
        cmd_ready  = (state == IDLE);
        case (state)
            IDLE: begin
                if (vsync_pulse)
                    state_next = UPDATE;
                else if (accept && layer_ok)
                    state_next = HOLD;
            end
            HOLD:    if (vsync_pulse) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame-start update: commit shadowed command, then fade, then step cadence.
    always_comb begin
        n_en   = en_q;
        n_step = '0;
        n_busy = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            n_gain[i]   = gain_q[i];
            n_target[i] = target_q[i];
            n_speed[i]  = speed_q[i];
            n_cnt[i]    = cnt_q[i];
            if (pending && (int'(sh_layer) == i)) begin
                case (sh_op)
                    2'd0: begin
                        n_speed[i] = sh_data;
                        n_cnt[i]   = 8'd0;
                    end
                    2'd1: n_target[i] = sh_data;
                    2'd2: n_en[i] = sh_data[0];
                    default: begin
                        n_gain[i]   = sh_data;
                        n_target[i] = sh_data;
                    end
                endcase
            end
            // Snap to target when within one step so the fade never overshoots.
            if (n_gain[i] < n_target[i]) begin
                if ((n_target[i] - n_gain[i]) <= STEP8)
                    n_gain[i] = n_target[i];
                else
                    n_gain[i] = n_gain[i] + STEP8;
            end else if (n_gain[i] > n_target[i]) begin
                if ((n_gain[i] - n_target[i]) <= STEP8)
                    n_gain[i] = n_target[i];
                else
                    n_gain[i] = n_gain[i] - STEP8;
            end
            if (n_speed[i] == 8'd0) begin
                n_cnt[i] = 8'd0;
            end else if (({1'b0, n_cnt[i]} + 9'd1) == {1'b0, n_speed[i]}) begin
                n_step[i] = 1'b1;
                n_cnt[i]  = 8'd0;
            end else begin
                n_cnt[i] = n_cnt[i] + 8'd1;
            end
            n_busy = n_busy | (n_gain[i] != n_target[i]);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            sh_layer   <= 2'd0;
            sh_op      <= 2'd0;
            sh_data    <= 8'd0;
            en_q       <= '1;
            layer_step <= '0;
            cmd_err    <= 1'b0;
            fade_busy  <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                gain_q[i]   <= DEFAULT_GAIN;
                target_q[i] <= DEFAULT_GAIN;
                speed_q[i]  <= DEFAULT_SPEED;
                cnt_q[i]    <= 8'd0;
            end
        end else begin
            state      <= state_next;
            layer_step <= '0;
            cmd_err    <= accept && !layer_ok;
            if (accept && layer_ok) begin
                pending  <= 1'b1;
                sh_layer <= cmd_layer;
                sh_op    <= cmd_op;
                sh_data  <= cmd_data;
            end
            if (state == UPDATE) begin
                pending    <= 1'b0;
                en_q       <= n_en;
                layer_step <= n_step;
                fade_busy  <= n_busy;
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    gain_q[i]   <= n_gain[i];
                    target_q[i] <= n_target[i];
                    speed_q[i]  <= n_speed[i];
                    cnt_q[i]    <= n_cnt[i];
                end
            end
        end
    end

`ifdef STARFIELD_SEQ_FRAME_COUNT_EN
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            frame_count   <= 16'd0;
            vsync_overrun <= 1'b0;
        end else begin
            vsync_overrun <= (state == UPDATE) && vsync_pulse;
            if (state == UPDATE)
                frame_count <= frame_count + 16'd1;
        end
    end
`endif

    always_comb begin
        layer_en = en_q;
        for (int i = 0; i < NUM_LAYERS; i++)
            layer_gain[8*i +: 8] = gain_q[i];
    end
endmodule

// File: tb/tb_starfield_sequencer.sv
// tb/tb_starfield_sequencer.sv - self-checking bench for starfield_sequencer
// Behavioural model of frames/commands compared every cycle, plus directed literal checks.
module tb_starfield_sequencer;
    localparam int NL = 3;
    localparam int FS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_pulse = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_layer = 2'd0;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        cmd_err;
    logic [2:0]  layer_en;
    logic [23:0] layer_gain;
    logic [2:0]  layer_step;
    logic        fade_busy;
`ifdef STARFIELD_SEQ_FRAME_COUNT_EN
    logic [15:0] frame_count;
    logic        vsync_overrun;
`endif

    starfield_sequencer dut (
        .pixel_clock (clk),
        .reset       (reset),
        .vsync_pulse (vsync_pulse),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_layer   (cmd_layer),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_err     (cmd_err),
        .layer_en    (layer_en),
        .layer_gain  (layer_gain),
        .layer_step  (layer_step),
        .fade_busy   (fade_busy)
`ifdef STARFIELD_SEQ_FRAME_COUNT_EN
        ,
        .frame_count   (frame_count),
        .vsync_overrun (vsync_overrun)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level bookkeeping of what each layer must show.
    int  m_gain [NL];
    int  m_target [NL];
    int  m_speed [NL];
    int  m_frames [NL];
    bit  m_en [NL];
    bit  m_pend, m_upd, m_ready, m_err, m_busy;
    int  p_layer, p_op, p_data;
    logic [2:0] m_step;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                m_gain[i] = 255; m_target[i] = 255; m_speed[i] = 1;
                m_frames[i] = 0; m_en[i] = 1'b1;
            end
            m_pend = 0; m_upd = 0; m_ready = 1; m_err = 0; m_busy = 0; m_step = 3'b000;
        end else begin
            m_step = 3'b000;
            m_err = 0;
            if (m_upd) begin
                if (m_pend) begin
                    case (p_op)
                        0: begin m_speed[p_layer] = p_data; m_frames[p_layer] = 0; end
                        1: m_target[p_layer] = p_data;
                        2: m_en[p_layer] = p_data[0];
                        default: begin m_gain[p_layer] = p_data; m_target[p_layer] = p_data; end
                    endcase
                    m_pend = 0;
                end
                m_busy = 0;
                for (int i = 0; i < NL; i++) begin
                    if (m_gain[i] < m_target[i])
                        m_gain[i] = (m_gain[i] + FS > m_target[i]) ? m_target[i] : m_gain[i] + FS;
                    else if (m_gain[i] > m_target[i])
                        m_gain[i] = (m_gain[i] - FS < m_target[i]) ? m_target[i] : m_gain[i] - FS;
                    m_frames[i]++;
                    if (m_speed[i] != 0 && (m_frames[i] % m_speed[i]) == 0)
                        m_step[i] = 1'b1;
                    if (m_gain[i] != m_target[i]) m_busy = 1;
                end
                m_upd = 0;
                m_ready = 1;
            end else begin
                if (cmd_valid && m_ready) begin
                    if (int'(cmd_layer) < NL) begin
                        m_pend = 1; p_layer = int'(cmd_layer); p_op = int'(cmd_op); p_data = int'(cmd_data);
                        m_ready = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                if (vsync_pulse) begin
                    m_upd = 1;
                    m_ready = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] eg;
            logic [2:0]  ee;
            eg = 32'(m_gain[2] * 65536 + m_gain[1] * 256 + m_gain[0]);
            ee = {m_en[2], m_en[1], m_en[0]};
            check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            check("cmd_err", 32'(cmd_err), 32'(m_err));
            check("layer_en", 32'(layer_en), 32'(ee));
            check("layer_gain", 32'(layer_gain), eg);
            check("layer_step", 32'(layer_step), 32'(m_step));
            check("fade_busy", 32'(fade_busy), 32'(m_busy));
        end
    end

    int step_cnt [NL] = '{0, 0, 0};
    int err_cnt = 0;
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++)
            if (layer_step[i]) step_cnt[i]++;
        if (cmd_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_vsync(input int gap);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_cmd(input logic [1:0] l, input logic [1:0] op, input logic [7:0] d,
                            input int vs_delay);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_layer = l; cmd_op = op; cmd_data = d;
        while (!cmd_ready) begin
            if (vs_delay > 0 && n == vs_delay) vsync_pulse = 1'b1;
            tick();
            vsync_pulse = 1'b0;
            n++;
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL cmd_timeout: cmd_ready low %0d cycles, required high", n);
                break;
            end
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    int b0, b1, b2, eb;

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_gain", 32'(layer_gain), 32'h00FFFFFF);
        check("rst_en", 32'(layer_en), 32'h7);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(fade_busy), 32'h0);

        b0 = step_cnt[0]; b1 = step_cnt[1]; b2 = step_cnt[2];
        repeat (2) do_vsync(99);
        check("idle_steps0", 32'(step_cnt[0] - b0), 32'd2);
        check("idle_steps2", 32'(step_cnt[2] - b2), 32'd2);

        send_cmd(2'd1, 2'd0, 8'd3, 0);
        b0 = step_cnt[0]; b1 = step_cnt[1]; b2 = step_cnt[2];
        repeat (7) do_vsync(5);
        check("speed3_l1", 32'(step_cnt[1] - b1), 32'd2);
        check("speed3_l0", 32'(step_cnt[0] - b0), 32'd7);
        check("speed3_l2", 32'(step_cnt[2] - b2), 32'd7);

        send_cmd(2'd0, 2'd1, 8'h10, 0);
        do_vsync(4);
        check("fade_first", 32'(layer_gain), 32'h00FFFFF7);
        check("fade_busy_on", 32'(fade_busy), 32'h1);
        repeat (28) do_vsync(4);
        check("fade_pen", 32'(layer_gain[7:0]), 32'h17);
        check("fade_busy_pen", 32'(fade_busy), 32'h1);
        do_vsync(4);
        check("fade_last", 32'(layer_gain), 32'h00FFFF10);
        check("fade_busy_off", 32'(fade_busy), 32'h0);
        do_vsync(4);
        check("fade_hold", 32'(layer_gain[7:0]), 32'h10);

        send_cmd(2'd2, 2'd3, 8'h40, 0);
        send_cmd(2'd2, 2'd3, 8'h20, 3);
        check("second_first", 32'(layer_gain[23:16]), 32'h40);
        do_vsync(4);
        check("second_commit", 32'(layer_gain), 32'h0020FF10);

        eb = err_cnt;
        send_cmd(2'd3, 2'd3, 8'h00, 0);
        tick();
        check("err_pulses", 32'(err_cnt - eb), 32'd1);
        check("err_ready", 32'(cmd_ready), 32'h1);
        do_vsync(4);
        check("err_nochange", 32'(layer_gain), 32'h0020FF10);

        send_cmd(2'd0, 2'd3, 8'h00, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        do_vsync(4);
        check("rst_drop", 32'(layer_gain), 32'h00FFFFFF);

        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 599) == 0);
            vsync_pulse = ($urandom_range(0, 9) == 0);
            cmd_valid   = ($urandom_range(0, 2) == 0);
            cmd_layer   = 2'($urandom_range(0, 3));
            cmd_op      = 2'($urandom_range(0, 3));
            cmd_data    = (cmd_op == 2'd0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            tick();
        end
        reset = 1'b0; vsync_pulse = 1'b0; cmd_valid = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
